// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Shared definitions for the hardwired control sequencer:
//               opcode and ALU codes, sequencer state encoding, the strobe
//               bundle produced by the decoder, and the per-opcode length of
//               the execute phase.
//               Optional feature macro: MUL_DIV_EN (mul/div/mfhi/mflo).
// Revision    : 1.0  initial release
// ============================================================================
package control_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 5;

  // Opcodes, field ir[31:27]
  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPW-1:0] OP_OR   = 5'b00010;
  localparam logic [OPW-1:0] OP_AND  = 5'b00011;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHRA = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b01001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b01010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_LD   = 5'b01110;
  localparam logic [OPW-1:0] OP_LDI  = 5'b01111;
  localparam logic [OPW-1:0] OP_ST   = 5'b10000;
  localparam logic [OPW-1:0] OP_BR   = 5'b10001;
  localparam logic [OPW-1:0] OP_JR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JAL  = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10100;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10101;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10110;
  localparam logic [OPW-1:0] OP_MFLO = 5'b10111;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11001;
  localparam logic [OPW-1:0] OP_MUL  = 5'b11010;
  localparam logic [OPW-1:0] OP_DIV  = 5'b11011;

  // ALU codes used where the operation is not the opcode itself
  localparam logic [ALUW-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALUW-1:0] ALU_OR  = 5'b00010;
  localparam logic [ALUW-1:0] ALU_AND = 5'b00011;

  typedef enum logic [3:0] {
    RESET  = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    FETCH2 = 4'd3,
    EXEC3  = 4'd4,
    EXEC4  = 4'd5,
    EXEC5  = 4'd6,
    EXEC6  = 4'd7,
    EXEC7  = 4'd8,
    HALT   = 4'd9
  } state_t;

  typedef struct packed {
    logic            run;
    logic            PCout;
    logic            PCin;
    logic            IncPC;
    logic            MARin;
    logic            MDRin;
    logic            MDRout;
    logic            IRin;
    logic            Yin;
    logic            read;
    logic            write;
    logic            RAMenable;
    logic            Gra;
    logic            Grb;
    logic            Grc;
    logic            Rin;
    logic            Rout;
    logic            BAout;
    logic            R15in;
    logic            Cout;
    logic            conin;
    logic            ZLOin;
    logic            ZLOout;
    logic            ZHIout;
    logic            ZMuxEnable;
    logic            ZSelect;
    logic            ZMuxOut;
    logic            OutPortenable;
    logic            PortInout;
`ifdef MUL_DIV_EN
    logic            HIin;
    logic            LOin;
    logic            HIout;
    logic            LOout;
`endif
    logic [ALUW-1:0] aluControl;
  } ctrl_t;

  // Index (3..7) of the final execute step; 0 means no execute phase (nop/unknown)
  function automatic logic [2:0] last_step(input logic [OPW-1:0] op);
    logic [2:0] r;
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  r = 3'd5;
      OP_NEG, OP_NOT, OP_JAL:            r = 3'd4;
      OP_LD, OP_ST:                      r = 3'd7;
      OP_BR:                             r = 3'd6;
      OP_JR, OP_IN, OP_OUT:              r = 3'd3;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV:                    r = 3'd6;
      OP_MFHI, OP_MFLO:                  r = 3'd3;
`endif
      default:                           r = 3'd0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_if.sv
`default_nettype none
// ============================================================================
// Module      : control_if
// Description : Control-unit to DataPath bundle: instruction/condition inputs
//               and every DataPath control strobe. The master side is the
//               control unit, the slave side the DataPath.
//               Optional feature macro: MUL_DIV_EN (adds HIin/LOin/HIout/LOout).
// Revision    : 1.0  initial release
// ============================================================================
interface control_if;
  import control_pkg::*;

  logic [31:0]     ir;
  logic            con_ff;
  logic            run;
  logic            PCout, PCin, IncPC;
  logic            MARin, MDRin, MDRout, IRin, Yin;
  logic            read, write, RAMenable;
  logic            Gra, Grb, Grc, Rin, Rout, BAout, R15in;
  logic            Cout, conin;
  logic            ZLOin, ZLOout, ZHIout;
  logic            ZMuxEnable, ZSelect, ZMuxOut;
  logic            OutPortenable, PortInout;
  logic [ALUW-1:0] aluControl;
`ifdef MUL_DIV_EN
  logic            HIin, LOin, HIout, LOout;
`endif

  modport master (
    input  ir, con_ff,
    output run, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           read, write, RAMenable, Gra, Grb, Grc, Rin, Rout, BAout, R15in,
           Cout, conin, ZLOin, ZLOout, ZHIout, ZMuxEnable, ZSelect, ZMuxOut,
           OutPortenable, PortInout, aluControl
`ifdef MUL_DIV_EN
    , output HIin, LOin, HIout, LOout
`endif
  );

  modport slave (
    output ir, con_ff,
    input  run, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           read, write, RAMenable, Gra, Grb, Grc, Rin, Rout, BAout, R15in,
           Cout, conin, ZLOin, ZLOout, ZHIout, ZMuxEnable, ZSelect, ZMuxOut,
           OutPortenable, PortInout, aluControl
`ifdef MUL_DIV_EN
    , input HIin, LOin, HIout, LOout
`endif
  );

endinterface
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Purely combinational strobe decoder. Maps the sequencer state
//               (plus the opcode during execute, and con_ff in the branch
//               step) to the full DataPath strobe bundle.
//               Optional feature macro: MUL_DIV_EN (mul/div/mfhi/mflo).
// Revision    : 1.0  initial release
// ============================================================================
module control_decode
  import control_pkg::*;
(
  input  state_t         state_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           con_ff_i,
  output ctrl_t          ctrl_o
);

  ctrl_t w_ctrl;

  // Strobe decode: all strobes default low, each step raises only its own set
  always_comb begin
    w_ctrl     = '0;
    w_ctrl.run = (state_i != RESET) && (state_i != HALT);
    case (state_i)
      FETCH0: begin
        w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1;
        w_ctrl.IncPC = 1'b1; w_ctrl.ZLOin = 1'b1;
      end
      FETCH1: begin
        w_ctrl.ZLOout    = 1'b1; w_ctrl.PCin  = 1'b1; w_ctrl.read = 1'b1;
        w_ctrl.RAMenable = 1'b1; w_ctrl.MDRin = 1'b1;
      end
      FETCH2: begin
        w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1;
      end
      EXEC3, EXEC4, EXEC5, EXEC6, EXEC7: begin
        case (opcode_i)
          OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
            case (state_i)
              EXEC3: begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
              EXEC4: begin
                w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.ZLOin = 1'b1;
                w_ctrl.aluControl = opcode_i;
              end
              EXEC5: begin
                w_ctrl.ZMuxEnable = 1'b1; w_ctrl.ZMuxOut = 1'b1;
                w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
              end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (state_i)
              EXEC3: begin
                w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.ZLOin = 1'b1;
                w_ctrl.aluControl = opcode_i;
              end
              EXEC4: begin
                w_ctrl.ZMuxEnable = 1'b1; w_ctrl.ZMuxOut = 1'b1;
                w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
              end
              default: ;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state_i)
              EXEC3: begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
              EXEC4: begin
                w_ctrl.Cout = 1'b1; w_ctrl.ZLOin = 1'b1;
                w_ctrl.aluControl = (opcode_i == OP_ANDI) ? ALU_AND :
                                    (opcode_i == OP_ORI)  ? ALU_OR  : ALU_ADD;
              end
              EXEC5: begin
                w_ctrl.ZMuxEnable = 1'b1; w_ctrl.ZMuxOut = 1'b1;
                w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
              end
              default: ;
            endcase
          end
          // ld, ldi and st share the base+offset address computation in T3-T4
          OP_LD, OP_LDI, OP_ST: begin
            case (state_i)
              EXEC3: begin w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.Yin = 1'b1; end
              EXEC4: begin
                w_ctrl.Cout = 1'b1; w_ctrl.ZLOin = 1'b1; w_ctrl.aluControl = ALU_ADD;
              end
              EXEC5: begin
                w_ctrl.ZMuxEnable = 1'b1; w_ctrl.ZMuxOut = 1'b1;
                if (opcode_i == OP_LDI) begin
                  w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                end else begin
                  w_ctrl.MARin = 1'b1;
                end
              end
              EXEC6: begin
                if (opcode_i == OP_LD) begin
                  w_ctrl.read = 1'b1; w_ctrl.RAMenable = 1'b1; w_ctrl.MDRin = 1'b1;
                end else if (opcode_i == OP_ST) begin
                  w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1;
                end
              end
              EXEC7: begin
                if (opcode_i == OP_LD) begin
                  w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
                end else if (opcode_i == OP_ST) begin
                  w_ctrl.write = 1'b1; w_ctrl.RAMenable = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (state_i)
              EXEC3: begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.conin = 1'b1; end
              EXEC4: begin w_ctrl.PCout = 1'b1; w_ctrl.Yin = 1'b1; end
              EXEC5: begin
                w_ctrl.Cout = 1'b1; w_ctrl.ZLOin = 1'b1; w_ctrl.aluControl = ALU_ADD;
              end
              // Branch target is only committed when the condition flop is set
              EXEC6: begin
                if (con_ff_i) begin
                  w_ctrl.ZMuxEnable = 1'b1; w_ctrl.ZMuxOut = 1'b1; w_ctrl.PCin = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_JR: begin
            if (state_i == EXEC3) begin
              w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1;
            end
          end
          OP_JAL: begin
            if (state_i == EXEC3) begin
              w_ctrl.PCout = 1'b1; w_ctrl.R15in = 1'b1;
            end else if (state_i == EXEC4) begin
              w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1;
            end
          end
          OP_IN: begin
            if (state_i == EXEC3) begin
              w_ctrl.PortInout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1;
            end
          end
          OP_OUT: begin
            if (state_i == EXEC3) begin
              w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.OutPortenable = 1'b1;
            end
          end
`ifdef MUL_DIV_EN
          OP_MUL, OP_DIV: begin
            case (state_i)
              EXEC3: begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Yin = 1'b1; end
              EXEC4: begin
                w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.ZLOin = 1'b1;
                w_ctrl.aluControl = opcode_i;
              end
              EXEC5: begin w_ctrl.ZLOout = 1'b1; w_ctrl.LOin = 1'b1; end
              EXEC6: begin w_ctrl.ZHIout = 1'b1; w_ctrl.HIin = 1'b1; end
              default: ;
            endcase
          end
          OP_MFHI, OP_MFLO: begin
            if (state_i == EXEC3) begin
              w_ctrl.HIout = (opcode_i == OP_MFHI);
              w_ctrl.LOout = (opcode_i == OP_MFLO);
              w_ctrl.Gra   = 1'b1;
              w_ctrl.Rin   = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctrl_o = w_ctrl;

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired control sequencer for the DataPath. Holds the step
//               register (RESET, FETCH0-2, EXEC3-7, HALT) and the next-step
//               logic; strobes come from control_decode.
//               Optional feature macro: MUL_DIV_EN (mul/div/mfhi/mflo and the
//               HIin/LOin/HIout/LOout strobes).
// Revision    : 1.0  initial release
// ============================================================================
module control_unit
  import control_pkg::*;
(
  input  logic      clock,
  input  logic      clear,
  control_if.master bus
);

  state_t         state_q;
  state_t         state_d;
  logic [OPW-1:0] w_opcode;
  logic [2:0]     w_last;
  ctrl_t          w_ctrl;
  logic           w_unused_ir;

  assign w_opcode    = bus.ir[31:27];
  assign w_last      = last_step(w_opcode);
  assign w_unused_ir = ^bus.ir[26:0];

  // Step register; clear forces RESET immediately so every strobe drops at once
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= RESET;
    else       state_q <= state_d;
  end

  // Next step: fetch is fixed, dispatch at T2 on the opcode, then run to the
  // instruction's last execute step and return to FETCH0
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:  state_d = FETCH0;
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = FETCH2;
      FETCH2: begin
        if (w_opcode == OP_HALT)  state_d = HALT;
        else if (w_last == 3'd0)  state_d = FETCH0;
        else                      state_d = EXEC3;
      end
      EXEC3:  state_d = (w_last == 3'd3) ? FETCH0 : EXEC4;
      EXEC4:  state_d = (w_last == 3'd4) ? FETCH0 : EXEC5;
      EXEC5:  state_d = (w_last == 3'd5) ? FETCH0 : EXEC6;
      EXEC6:  state_d = (w_last == 3'd6) ? FETCH0 : EXEC7;
      EXEC7:  state_d = FETCH0;
      HALT:   state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  control_decode u_decode (
    .state_i  (state_q),
    .opcode_i (w_opcode),
    .con_ff_i (bus.con_ff),
    .ctrl_o   (w_ctrl)
  );

  assign bus.run           = w_ctrl.run;
  assign bus.PCout         = w_ctrl.PCout;
  assign bus.PCin          = w_ctrl.PCin;
  assign bus.IncPC         = w_ctrl.IncPC;
  assign bus.MARin         = w_ctrl.MARin;
  assign bus.MDRin         = w_ctrl.MDRin;
  assign bus.MDRout        = w_ctrl.MDRout;
  assign bus.IRin          = w_ctrl.IRin;
  assign bus.Yin           = w_ctrl.Yin;
  assign bus.read          = w_ctrl.read;
  assign bus.write         = w_ctrl.write;
  assign bus.RAMenable     = w_ctrl.RAMenable;
  assign bus.Gra           = w_ctrl.Gra;
  assign bus.Grb           = w_ctrl.Grb;
  assign bus.Grc           = w_ctrl.Grc;
  assign bus.Rin           = w_ctrl.Rin;
  assign bus.Rout          = w_ctrl.Rout;
  assign bus.BAout         = w_ctrl.BAout;
  assign bus.R15in         = w_ctrl.R15in;
  assign bus.Cout          = w_ctrl.Cout;
  assign bus.conin         = w_ctrl.conin;
  assign bus.ZLOin         = w_ctrl.ZLOin;
  assign bus.ZLOout        = w_ctrl.ZLOout;
  assign bus.ZHIout        = w_ctrl.ZHIout;
  assign bus.ZMuxEnable    = w_ctrl.ZMuxEnable;
  assign bus.ZSelect       = w_ctrl.ZSelect;
  assign bus.ZMuxOut       = w_ctrl.ZMuxOut;
  assign bus.OutPortenable = w_ctrl.OutPortenable;
  assign bus.PortInout     = w_ctrl.PortInout;
  assign bus.aluControl    = w_ctrl.aluControl;
`ifdef MUL_DIV_EN
  assign bus.HIin          = w_ctrl.HIin;
  assign bus.LOin          = w_ctrl.LOin;
  assign bus.HIout         = w_ctrl.HIout;
  assign bus.LOout         = w_ctrl.LOout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit. Each task
//               walks one instruction step by step and compares the whole
//               strobe word against hand-built expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

  logic clock = 1'b0;
  logic clear;
  int   n_vec = 0;
  int   n_err = 0;

  control_if bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Strobe word layout: {run, 28 strobes, aluControl[4:0]}
  localparam logic [33:0] S_RUN    = 34'h1 << 33;
  localparam logic [33:0] S_PCOUT  = 34'h1 << 32;
  localparam logic [33:0] S_PCIN   = 34'h1 << 31;
  localparam logic [33:0] S_INCPC  = 34'h1 << 30;
  localparam logic [33:0] S_MARIN  = 34'h1 << 29;
  localparam logic [33:0] S_MDRIN  = 34'h1 << 28;
  localparam logic [33:0] S_MDROUT = 34'h1 << 27;
  localparam logic [33:0] S_IRIN   = 34'h1 << 26;
  localparam logic [33:0] S_YIN    = 34'h1 << 25;
  localparam logic [33:0] S_READ   = 34'h1 << 24;
  localparam logic [33:0] S_WRITE  = 34'h1 << 23;
  localparam logic [33:0] S_RAMEN  = 34'h1 << 22;
  localparam logic [33:0] S_GRA    = 34'h1 << 21;
  localparam logic [33:0] S_GRB    = 34'h1 << 20;
  localparam logic [33:0] S_GRC    = 34'h1 << 19;
  localparam logic [33:0] S_RIN    = 34'h1 << 18;
  localparam logic [33:0] S_ROUT   = 34'h1 << 17;
  localparam logic [33:0] S_BAOUT  = 34'h1 << 16;
  localparam logic [33:0] S_R15IN  = 34'h1 << 15;
  localparam logic [33:0] S_COUT   = 34'h1 << 14;
  localparam logic [33:0] S_CONIN  = 34'h1 << 13;
  localparam logic [33:0] S_ZLOIN  = 34'h1 << 12;
  localparam logic [33:0] S_ZLOOUT = 34'h1 << 11;
  localparam logic [33:0] S_ZHIOUT = 34'h1 << 10;
  localparam logic [33:0] S_ZMUXEN = 34'h1 << 9;
  localparam logic [33:0] S_ZSEL   = 34'h1 << 8;
  localparam logic [33:0] S_ZMUXO  = 34'h1 << 7;
  localparam logic [33:0] S_OUTP   = 34'h1 << 6;
  localparam logic [33:0] S_PORTIN = 34'h1 << 5;
  localparam logic [33:0] ZLOW     = S_ZMUXEN | S_ZMUXO;

  localparam logic [33:0] E_F0 = S_RUN | S_PCOUT | S_MARIN | S_INCPC | S_ZLOIN;
  localparam logic [33:0] E_F1 = S_RUN | S_ZLOOUT | S_PCIN | S_READ | S_RAMEN | S_MDRIN;
  localparam logic [33:0] E_F2 = S_RUN | S_MDROUT | S_IRIN;

  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_NEG  = 5'b01001;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10001;
  localparam logic [4:0] OP_JR   = 5'b10010;
  localparam logic [4:0] OP_JAL  = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10100;
  localparam logic [4:0] OP_OUT  = 5'b10101;
  localparam logic [4:0] OP_MFHI = 5'b10110;
  localparam logic [4:0] OP_HALT = 5'b11001;
  localparam logic [4:0] OP_MUL  = 5'b11010;
  localparam logic [4:0] OP_BAD  = 5'b11111;

  logic [33:0] obs;
  assign obs = {bus.run, bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.read, bus.write, bus.RAMenable, bus.Gra, bus.Grb,
                bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.R15in, bus.Cout, bus.conin,
                bus.ZLOin, bus.ZLOout, bus.ZHIout, bus.ZMuxEnable, bus.ZSelect, bus.ZMuxOut,
                bus.OutPortenable, bus.PortInout, bus.aluControl};

`ifdef MUL_DIV_EN
  logic [3:0] ext;
  assign ext = {bus.HIin, bus.LOin, bus.HIout, bus.LOout};
`endif

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Clear held: all strobes low, then first clock after release enters FETCH0
  task automatic test_reset();
    clear      = 1'b1;
    bus.ir     = 32'h0;
    bus.con_ff = 1'b0;
    tick();
    tick();
    n_vec++;
    if (obs !== 34'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 34'h0);
    end
    clear = 1'b0;
    tick();
    n_vec++;
    if (obs !== E_F0) begin
      n_err++;
      $display("FAIL reset_to_fetch0: got %h expected %h", obs, E_F0);
    end
  endtask

  // andi r1,r2,0x25: 6 cycles, next T0 on cycle 7
  task automatic test_andi();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_ANDI, 4'd1, 4'd2, 19'h25);
    exp = {E_F1, E_F2, S_RUN | S_GRB | S_ROUT | S_YIN,
           S_RUN | S_COUT | S_ZLOIN | 34'h3, S_RUN | ZLOW | S_GRA | S_RIN, E_F0};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL andi cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_LD, 4'd3, 4'd4, 19'h10);
    exp = {E_F1, E_F2, S_RUN | S_GRB | S_BAOUT | S_YIN, S_RUN | S_COUT | S_ZLOIN,
           S_RUN | ZLOW | S_MARIN, S_RUN | S_READ | S_RAMEN | S_MDRIN,
           S_RUN | S_MDROUT | S_GRA | S_RIN, E_F0};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL ld cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
  endtask

  task automatic test_st();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_ST, 4'd5, 4'd6, 19'h7);
    exp = {E_F1, E_F2, S_RUN | S_GRB | S_BAOUT | S_YIN, S_RUN | S_COUT | S_ZLOIN,
           S_RUN | ZLOW | S_MARIN, S_RUN | S_GRA | S_ROUT | S_MDRIN,
           S_RUN | S_WRITE | S_RAMEN, E_F0};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL st cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
  endtask

  // br not taken then taken: only T6 differs, 7 cycles either way
  task automatic test_br();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_BR, 4'd2, 4'd0, 19'h40);
    for (int t = 0; t < 2; t++) begin
      bus.con_ff = (t == 1);
      exp = {E_F1, E_F2, S_RUN | S_GRA | S_ROUT | S_CONIN, S_RUN | S_PCOUT | S_YIN,
             S_RUN | S_COUT | S_ZLOIN,
             (t == 1) ? (S_RUN | ZLOW | S_PCIN) : S_RUN, E_F0};
      for (int i = 0; i < exp.size(); i++) begin
        tick();
        n_vec++;
        if (obs !== exp[i]) begin
          n_err++;
          $display("FAIL br con_ff=%0d cycle %0d: got %h expected %h", t, i + 2, obs, exp[i]);
        end
      end
    end
    bus.con_ff = 1'b0;
  endtask

  // Back-to-back short instructions of differing lengths
  task automatic test_back_to_back();
    logic [4:0]  ops [0:5];
    logic [33:0] exp[$];
    ops = '{OP_SUB, OP_NEG, OP_JAL, OP_JR, OP_IN, OP_OUT};
    for (int k = 0; k < 6; k++) begin
      bus.ir = mk_ir(ops[k], 4'd7, 4'd8, 19'h0);
      case (k)
        0: exp = {E_F1, E_F2, S_RUN | S_GRB | S_ROUT | S_YIN,
                  S_RUN | S_GRC | S_ROUT | S_ZLOIN | 34'h1, S_RUN | ZLOW | S_GRA | S_RIN, E_F0};
        1: exp = {E_F1, E_F2, S_RUN | S_GRB | S_ROUT | S_ZLOIN | 34'h9,
                  S_RUN | ZLOW | S_GRA | S_RIN, E_F0};
        2: exp = {E_F1, E_F2, S_RUN | S_PCOUT | S_R15IN, S_RUN | S_GRA | S_ROUT | S_PCIN, E_F0};
        3: exp = {E_F1, E_F2, S_RUN | S_GRA | S_ROUT | S_PCIN, E_F0};
        4: exp = {E_F1, E_F2, S_RUN | S_PORTIN | S_GRA | S_RIN, E_F0};
        default: exp = {E_F1, E_F2, S_RUN | S_GRA | S_ROUT | S_OUTP, E_F0};
      endcase
      for (int i = 0; i < exp.size(); i++) begin
        tick();
        n_vec++;
        if (obs !== exp[i]) begin
          n_err++;
          $display("FAIL b2b op=%b cycle %0d: got %h expected %h", ops[k], i + 2, obs, exp[i]);
        end
      end
    end
  endtask

  // Clear during st T6: strobes drop in the same cycle, write never seen
  task automatic test_clear_abort();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_ST, 4'd1, 4'd1, 19'h3);
    exp = {E_F1, E_F2, S_RUN | S_GRB | S_BAOUT | S_YIN, S_RUN | S_COUT | S_ZLOIN,
           S_RUN | ZLOW | S_MARIN, S_RUN | S_GRA | S_ROUT | S_MDRIN};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL abort pre cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
    #1 clear = 1'b1;
    #1;
    n_vec++;
    if (obs !== 34'h0) begin
      n_err++;
      $display("FAIL abort same_cycle: got %h expected %h", obs, 34'h0);
    end
    tick();
    n_vec++;
    if (obs !== 34'h0 || bus.write !== 1'b0) begin
      n_err++;
      $display("FAIL abort held: got %h write %b expected %h write 0", obs, bus.write, 34'h0);
    end
    clear = 1'b0;
    tick();
    n_vec++;
    if (obs !== E_F0) begin
      n_err++;
      $display("FAIL abort refetch: got %h expected %h", obs, E_F0);
    end
  endtask

  // Unknown opcode returns to FETCH0 after T2; halt parks with run=0 until clear
  task automatic test_nop_halt();
    logic [33:0] exp[$];
    bus.ir = mk_ir(OP_BAD, 4'd0, 4'd0, 19'h0);
    exp = {E_F1, E_F2, E_F0};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL bad_opcode cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
    bus.ir = mk_ir(OP_HALT, 4'd0, 4'd0, 19'h0);
    exp = {E_F1, E_F2};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if (obs !== exp[i]) begin
        n_err++;
        $display("FAIL halt fetch cycle %0d: got %h expected %h", i + 2, obs, exp[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (obs !== 34'h0) begin
        n_err++;
        $display("FAIL halt idle %0d: got %h expected %h", i, obs, 34'h0);
      end
    end
    clear = 1'b1;
    #2;
    n_vec++;
    if (obs !== 34'h0) begin
      n_err++;
      $display("FAIL halt clear: got %h expected %h", obs, 34'h0);
    end
    clear = 1'b0;
    tick();
    n_vec++;
    if (obs !== E_F0) begin
      n_err++;
      $display("FAIL halt refetch: got %h expected %h", obs, E_F0);
    end
  endtask

  task automatic test_muldiv();
`ifdef MUL_DIV_EN
    logic [37:0] exp[$];
    bus.ir = mk_ir(OP_MUL, 4'd2, 4'd3, 19'h0);
    exp = {{E_F1, 4'b0000}, {E_F2, 4'b0000},
           {S_RUN | S_GRA | S_ROUT | S_YIN, 4'b0000},
           {S_RUN | S_GRB | S_ROUT | S_ZLOIN | 34'h1A, 4'b0000},
           {S_RUN | S_ZLOOUT, 4'b0100},
           {S_RUN | S_ZHIOUT, 4'b1000},
           {E_F0, 4'b0000}};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if ({obs, ext} !== exp[i]) begin
        n_err++;
        $display("FAIL mul cycle %0d: got %h expected %h", i + 2, {obs, ext}, exp[i]);
      end
    end
    bus.ir = mk_ir(OP_MFHI, 4'd4, 4'd0, 19'h0);
    exp = {{E_F1, 4'b0000}, {E_F2, 4'b0000},
           {S_RUN | S_GRA | S_RIN, 4'b0010}, {E_F0, 4'b0000}};
    for (int i = 0; i < exp.size(); i++) begin
      tick();
      n_vec++;
      if ({obs, ext} !== exp[i]) begin
        n_err++;
        $display("FAIL mfhi cycle %0d: got %h expected %h", i + 2, {obs, ext}, exp[i]);
      end
    end
`else
    logic [33:0] exp[$];
    logic [4:0]  ops [0:1];
    ops = '{OP_MUL, OP_MFHI};
    for (int k = 0; k < 2; k++) begin
      bus.ir = mk_ir(ops[k], 4'd2, 4'd3, 19'h0);
      exp = {E_F1, E_F2, E_F0};
      for (int i = 0; i < exp.size(); i++) begin
        tick();
        n_vec++;
        if (obs !== exp[i]) begin
          n_err++;
          $display("FAIL muldiv_as_nop op=%b cycle %0d: got %h expected %h",
                   ops[k], i + 2, obs, exp[i]);
        end
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_andi();
    test_ld();
    test_st();
    test_br();
    test_back_to_back();
    test_clear_abort();
    test_nop_halt();
    test_muldiv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
